// File: rtl/hpb_cfg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hpb_cfg_decoder
// Brief    : Decodes the core-clock host configuration stream into strategy
//            rule-table writes, a global strategy enable and command/error
//            counters. Multi-beat command FSM with table backpressure and a
//            bulk table clear.
// Revision : 1.0 - initial release
// ============================================================================
module hpb_cfg_decoder #(
  parameter int CFG_W     = 64,
  parameter int NUM_RULES = 16,
  parameter int IDX_W     = $clog2(NUM_RULES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_config_valid,
  input  logic [CFG_W-1:0] in_config_data,
  output logic             in_config_accept,
  output logic             rule_wr_en,
  input  logic             rule_wr_ready,
  output logic [IDX_W-1:0] rule_wr_idx,
  output logic [63:0]      rule_wr_symbol,
  output logic [31:0]      rule_wr_price,
  output logic [15:0]      rule_wr_volume,
  output logic             global_enable,
  output logic [15:0]      cmd_cnt,
  output logic [15:0]      err_cnt
);

  localparam logic [7:0]       C_OP_WRITE  = 8'h01;
  localparam logic [7:0]       C_OP_ENABLE = 8'h02;
  localparam logic [7:0]       C_OP_CLEAR  = 8'h03;
  // Header index is a full 8-bit field; compare it against the depth in 9 bits
  // so a depth of 256 still works.
  localparam logic [8:0]       C_DEPTH     = 9'(NUM_RULES);
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_RULES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_WRITE   = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hdr_idx_q, hdr_idx_d;
  logic [15:0]      hdr_vol_q, hdr_vol_d;
  logic [31:0]      hdr_price_q, hdr_price_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             accept_q, accept_d;
  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [63:0]      wr_sym_q, wr_sym_d;
  logic [31:0]      wr_price_q, wr_price_d;
  logic [15:0]      wr_vol_q, wr_vol_d;
  logic             ge_q, ge_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      err_q, err_d;
  logic             cmd_inc;
  logic             err_inc;

  logic             w_beat;
  logic             w_hs;
  logic [7:0]       w_op;

  assign w_beat = in_config_valid && accept_q;
  assign w_hs   = wr_en_q && rule_wr_ready;
  assign w_op   = in_config_data[63:56];

  // Next-state, datapath and counter-event decode for the command FSM.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    hdr_vol_d   = hdr_vol_q;
    hdr_price_d = hdr_price_q;
    clr_cnt_d   = clr_cnt_q;
    wr_idx_d    = wr_idx_q;
    wr_sym_d    = wr_sym_q;
    wr_price_d  = wr_price_q;
    wr_vol_d    = wr_vol_q;
    ge_d        = ge_q;
    cmd_inc     = 1'b0;
    err_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_beat) begin
          case (w_op)
            C_OP_WRITE: begin
              hdr_idx_d   = in_config_data[55:48];
              hdr_vol_d   = in_config_data[47:32];
              hdr_price_d = in_config_data[31:0];
              state_d     = S_PAYLOAD;
            end
            C_OP_ENABLE: begin
              ge_d    = in_config_data[0];
              cmd_inc = 1'b1;
            end
            C_OP_CLEAR: begin
              clr_cnt_d  = '0;
              wr_idx_d   = '0;
              wr_sym_d   = '0;
              wr_price_d = '0;
              wr_vol_d   = '0;
              state_d    = S_CLEAR;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (w_beat) begin
          if ({1'b0, hdr_idx_q} < C_DEPTH) begin
            wr_idx_d   = hdr_idx_q[IDX_W-1:0];
            wr_sym_d   = in_config_data[63:0];
            wr_price_d = hdr_price_q;
            wr_vol_d   = hdr_vol_q;
            state_d    = S_WRITE;
          end else begin
            // Out-of-range index: payload swallowed, nothing written.
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (w_hs) begin
          cmd_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (w_hs) begin
          if (clr_cnt_q == C_LAST_IDX) begin
            cmd_inc = 1'b1;
            state_d = S_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            wr_idx_d  = clr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    accept_d = (state_d == S_IDLE) || (state_d == S_PAYLOAD);
    wr_en_d  = (state_d == S_WRITE) || (state_d == S_CLEAR);

    cmd_d = cmd_q + {15'd0, cmd_inc};
    err_d = (err_inc && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

  // State, datapath and counter registers; async reset abandons any command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hdr_idx_q   <= '0;
      hdr_vol_q   <= '0;
      hdr_price_q <= '0;
      clr_cnt_q   <= '0;
      accept_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_sym_q    <= '0;
      wr_price_q  <= '0;
      wr_vol_q    <= '0;
      ge_q        <= 1'b0;
      cmd_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      hdr_vol_q   <= hdr_vol_d;
      hdr_price_q <= hdr_price_d;
      clr_cnt_q   <= clr_cnt_d;
      accept_q    <= accept_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_sym_q    <= wr_sym_d;
      wr_price_q  <= wr_price_d;
      wr_vol_q    <= wr_vol_d;
      ge_q        <= ge_d;
      cmd_q       <= cmd_d;
      err_q       <= err_d;
    end
  end

  assign in_config_accept = accept_q;
  assign rule_wr_en       = wr_en_q;
  assign rule_wr_idx      = wr_idx_q;
  assign rule_wr_symbol   = wr_sym_q;
  assign rule_wr_price    = wr_price_q;
  assign rule_wr_volume   = wr_vol_q;
  assign global_enable    = ge_q;
  assign cmd_cnt          = cmd_q;
  assign err_cnt          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hpb_cfg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpb_cfg_decoder
// Brief    : Self-checking bench for hpb_cfg_decoder: directed timing cases
//            plus randomized command traffic against a command-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpb_cfg_decoder;

  localparam int NUM_RULES = 16;
  localparam int IDX_W     = $clog2(NUM_RULES);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_config_valid = 1'b0;
  logic [63:0]      in_config_data = '0;
  logic             in_config_accept;
  logic             rule_wr_en;
  logic             rule_wr_ready = 1'b1;
  logic [IDX_W-1:0] rule_wr_idx;
  logic [63:0]      rule_wr_symbol;
  logic [31:0]      rule_wr_price;
  logic [15:0]      rule_wr_volume;
  logic             global_enable;
  logic [15:0]      cmd_cnt;
  logic [15:0]      err_cnt;

  hpb_cfg_decoder #(.CFG_W(64), .NUM_RULES(NUM_RULES)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_config_valid  (in_config_valid),
    .in_config_data   (in_config_data),
    .in_config_accept (in_config_accept),
    .rule_wr_en       (rule_wr_en),
    .rule_wr_ready    (rule_wr_ready),
    .rule_wr_idx      (rule_wr_idx),
    .rule_wr_symbol   (rule_wr_symbol),
    .rule_wr_price    (rule_wr_price),
    .rule_wr_volume   (rule_wr_volume),
    .global_enable    (global_enable),
    .cmd_cnt          (cmd_cnt),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  idx;
    logic [63:0] sym;
    logic [31:0] price;
    logic [15:0] vol;
  } wr_t;

  wr_t         exp_q[$];
  logic        exp_ge;
  logic [15:0] exp_cmd;
  logic [15:0] exp_err;

  task automatic m_clear();
    exp_q.delete();
    exp_ge  = 1'b0;
    exp_cmd = '0;
    exp_err = '0;
  endtask

  task automatic m_err();
    if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
  endtask

  task automatic m_write(input logic [7:0] idx, input logic [15:0] vol,
                         input logic [31:0] price, input logic [63:0] sym);
    wr_t w;
    if (int'(idx) < NUM_RULES) begin
      w.idx = idx; w.sym = sym; w.price = price; w.vol = vol;
      exp_q.push_back(w);
      exp_cmd = exp_cmd + 16'd1;
    end else begin
      m_err();
    end
  endtask

  task automatic m_clear_table();
    wr_t w;
    for (int i = 0; i < NUM_RULES; i++) begin
      w = '0;
      w.idx = 8'(i);
      exp_q.push_back(w);
    end
    exp_cmd = exp_cmd + 16'd1;
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] idx,
                                      input logic [15:0] vol, input logic [31:0] price);
    return {op, idx, vol, price};
  endfunction

  // ---------------- ready generator ----------------
  int rdy_mode = 0; // 0: directed, 1: random, 2: toggle

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) rule_wr_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) rule_wr_ready = !rule_wr_ready;
  end

  // ---------------- monitor ----------------
  logic             live = 1'b0;
  logic             prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_idx;
  logic [63:0]      prev_sym;
  logic [31:0]      prev_price;
  logic [15:0]      prev_vol;
  wr_t              mon_e;

  always @(posedge clk or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  always @(negedge clk) begin
    if (reset || !live) begin
      prev_stall = 1'b0;
    end else begin
      chk("acc_xor_wen", in_config_accept, !rule_wr_en);
      if (prev_stall) begin
        chk("stall_wen", rule_wr_en, 1'b1);
        chk("stall_fields", {rule_wr_idx, rule_wr_symbol, rule_wr_price, rule_wr_volume},
            {prev_idx, prev_sym, prev_price, prev_vol});
      end
      if (rule_wr_en && rule_wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_idx", 64'(rule_wr_idx), 64'(mon_e.idx));
          chk("wr_sym", rule_wr_symbol, mon_e.sym);
          chk("wr_price", 64'(rule_wr_price), 64'(mon_e.price));
          chk("wr_vol", 64'(rule_wr_volume), 64'(mon_e.vol));
        end
      end
      prev_stall = rule_wr_en && !rule_wr_ready;
      prev_idx   = rule_wr_idx;
      prev_sym   = rule_wr_symbol;
      prev_price = rule_wr_price;
      prev_vol   = rule_wr_volume;
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic send_beat(input logic [63:0] d);
    int g = 0;
    in_config_valid = 1'b1;
    in_config_data  = d;
    @(negedge clk);
    while (!in_config_accept && g < 500) begin
      g++;
      @(negedge clk);
    end
    if (!in_config_accept) begin
      chk("beat_timeout", in_config_accept, 1'b1);
      $fatal(1, "beat never accepted");
    end
    @(posedge clk); #1;
    in_config_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (!(in_config_accept && exp_q.size() == 0) && g < 500) begin
      g++;
      @(negedge clk);
    end
    chk("idle_timeout", in_config_accept, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] idx, input logic [15:0] vol,
                          input logic [31:0] price, input logic [63:0] sym);
    m_write(idx, vol, price, sym);
    send_beat(hdr(8'h01, idx, vol, price));
    send_beat(sym);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", in_config_accept, 1'b0);
    chk("rst_wen", rule_wr_en, 1'b0);
    chk("rst_cnt", {cmd_cnt, err_cnt}, 32'd0);
    chk("rst_ge", global_enable, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("acc_before_edge", in_config_accept, 1'b0);
    @(negedge clk);
    chk("acc_after_edge", in_config_accept, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] sym;
  int          r;
  logic [7:0]  op;

  initial begin
    rdy_mode = 0;
    rule_wr_ready = 1'b1;

    // Bad opcode, then out-of-range write: both beats consumed, only errors.
    do_reset();
    m_err();
    send_beat(hdr(8'h7F, 8'h00, 16'h0, 32'h0));
    do_write(8'h20, 16'd7, 32'd9, 64'h1122334455667788);
    wait_idle();
    chk("err_after_bad", err_cnt, exp_err);
    chk("cmd_after_bad", cmd_cnt, exp_cmd);

    // Single write with 3-cycle turnaround.
    do_reset();
    sym = 64'h4142434400000000;
    m_write(8'd5, 16'd100, 32'd10000, sym);
    in_config_valid = 1'b1;
    in_config_data  = 64'h01_05_0064_00002710;
    @(negedge clk); chk("hdr_acc", in_config_accept, 1'b1);
    @(posedge clk); #1; in_config_data = sym;
    @(negedge clk); chk("pay_acc", in_config_accept, 1'b1);
    chk("pay_wen", rule_wr_en, 1'b0);
    @(posedge clk); #1; in_config_valid = 1'b0;
    @(negedge clk);
    chk("w_wen", rule_wr_en, 1'b1);
    chk("w_acc", in_config_accept, 1'b0);
    chk("w_fields", {rule_wr_idx, rule_wr_symbol, rule_wr_price, rule_wr_volume},
        {4'd5, sym, 32'd10000, 16'd100});
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_wen", rule_wr_en, 1'b0);
    chk("post_acc", in_config_accept, 1'b1);
    chk("post_cmd", cmd_cnt, exp_cmd);
    @(posedge clk); #1;

    // Same write with the table stalling for 4 cycles.
    m_write(8'd5, 16'd100, 32'd10000, sym);
    rule_wr_ready = 1'b0;
    send_beat(64'h01_05_0064_00002710);
    send_beat(sym);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_wen_hi", rule_wr_en, 1'b1);
      chk("stall_acc_lo", in_config_accept, 1'b0);
      @(posedge clk); #1;
    end
    rule_wr_ready = 1'b1;
    @(negedge clk); chk("stall_last_wen", rule_wr_en, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_done_wen", rule_wr_en, 1'b0);
    chk("stall_done_acc", in_config_accept, 1'b1);
    chk("stall_cmd", cmd_cnt, exp_cmd);
    @(posedge clk); #1;

    // ENABLE 1 then 0 back-to-back.
    in_config_valid = 1'b1;
    in_config_data  = hdr(8'h02, 8'h0, 16'h0, 32'h1);
    exp_cmd = exp_cmd + 16'd1;
    @(negedge clk); chk("en1_acc", in_config_accept, 1'b1);
    @(posedge clk); #1; in_config_data = hdr(8'h02, 8'h0, 16'h0, 32'h0);
    exp_cmd = exp_cmd + 16'd1;
    @(negedge clk);
    chk("ge_one", global_enable, 1'b1);
    chk("en0_acc", in_config_accept, 1'b1);
    @(posedge clk); #1; in_config_valid = 1'b0;
    @(negedge clk);
    chk("ge_zero", global_enable, 1'b0);
    chk("en_cmd", cmd_cnt, exp_cmd);
    @(posedge clk); #1;

    // CLEAR with ready toggling every cycle.
    rdy_mode = 2;
    m_clear_table();
    send_beat(hdr(8'h03, 8'h0, 16'h0, 32'h0));
    wait_idle();
    chk("clr_cmd", cmd_cnt, exp_cmd);
    chk("clr_q_empty", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;
    rule_wr_ready = 1'b1;

    // Reset pulsed while a write is stalled.
    exp_ge = 1'b1;
    exp_cmd = exp_cmd + 16'd1;
    send_beat(hdr(8'h02, 8'h0, 16'h0, 32'h1));
    rule_wr_ready = 1'b0;
    send_beat(hdr(8'h01, 8'd3, 16'd1, 32'd2));
    send_beat(64'hDEADBEEF);
    @(negedge clk);
    chk("pre_rst_wen", rule_wr_en, 1'b1);
    chk("pre_rst_ge", global_enable, exp_ge);
    #2 reset = 1'b1;
    m_clear();
    #1;
    chk("mid_rst_wen", rule_wr_en, 1'b0);
    chk("mid_rst_acc", in_config_accept, 1'b0);
    chk("mid_rst_cnt", {cmd_cnt, err_cnt}, 32'd0);
    chk("mid_rst_ge", global_enable, 1'b0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); chk("rel_acc_pre", in_config_accept, 1'b0);
    @(negedge clk); chk("rel_acc_post", in_config_accept, 1'b1);
    chk("rel_wen", rule_wr_en, 1'b0);
    @(posedge clk); #1;
    rule_wr_ready = 1'b1;

    // Randomized command traffic with random table backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        do_write(8'($urandom_range(0, NUM_RULES - 1)), 16'($urandom), $urandom,
                 {$urandom, $urandom});
      end else if (r < 55) begin
        do_write(8'($urandom_range(NUM_RULES, 255)), 16'($urandom), $urandom,
                 {$urandom, $urandom});
      end else if (r < 75) begin
        sym = {$urandom, $urandom};
        exp_ge = sym[0];
        exp_cmd = exp_cmd + 16'd1;
        send_beat({8'h02, sym[55:0]});
      end else if (r < 80) begin
        m_clear_table();
        send_beat({8'h03, 24'($urandom), $urandom});
      end else begin
        op = 8'($urandom_range(4, 256));
        m_err();
        send_beat({op, 24'($urandom), $urandom});
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    chk("rand_cmd", cmd_cnt, exp_cmd);
    chk("rand_err", err_cnt, exp_err);
    chk("rand_ge", global_enable, exp_ge);
    chk("rand_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
